// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- UART receiver for 8-N-1 frames (8-E-1 when UART_RX_PARITY_EN is
// defined), LSB first. Synchronises rxd, validates the start bit at mid-bit,
// samples every following bit at mid-bit and reports the byte with a
// one-cycle rx_done strobe. A low stop bit gives a frame_err strobe and parks
// the receiver until the line returns high.
//
// Build option:
//   UART_RX_PARITY_EN  adds an even-parity bit between data and stop;
//                      parity_err pulses with rx_done on mismatch.
//
// Parameters:
//   BAUD_DIV  clock cycles per serial bit (>= 4)
//   HALF_DIV  cycles from the synchronised start edge to the start mid-sample
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   rxd         serial input, idles high, asynchronous to clk
//   data_out    last good byte, held until the next good frame completes
//   rx_done     one-cycle strobe, frame received with a valid stop bit
//   frame_err   one-cycle strobe, stop bit sampled low
//   parity_err  one-cycle strobe with rx_done on parity mismatch (0 if no parity)
//   busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD_DIV = 2605,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY  = 3'd5
`endif
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            bit_tick;
  logic            cnt_clr;
  logic            shift_en;
  logic            enter_data;
  logic            stop_ok;
  logic            stop_bad;
`ifdef UART_RX_PARITY_EN
  logic            par_en;
  logic            par_bit;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_tick  = (cnt == BIT_LAST);
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        // Still high at mid start bit means the edge was a glitch.
        if (cnt == HALF_LAST) state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          par_en    = 1'b1;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be seen.
        if (bit_tick) begin
          if (rx_s) begin
            stop_ok   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        // A stuck-low line must not be taken as a new start bit.
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_clr = 1'b1;
  end

  assign enter_data = (state_nxt == S_DATA) && (state != S_DATA);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
    end else begin
      if (cnt_clr) cnt <= '0;
      else         cnt <= cnt + CW'(1);
      if (enter_data)    bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // LSB arrives first, so shifting in at the MSB leaves bit 0 at shreg[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= 8'h00;
      data_out  <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= stop_ok;
      frame_err <= stop_bad;
      if (shift_en) shreg    <= {rx_s, shreg[7:1]};
      if (stop_ok)  data_out <= shreg;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: XOR over data and parity bit is 1 only on mismatch.
  function automatic logic even_parity_err(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rx_s;
      parity_err <= stop_ok & even_parity_err(shreg, par_bit);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx with BAUD_DIV=16.
// Frames are driven on rxd at falling clock edges; a monitor on the falling
// edge logs every rx_done / frame_err / parity_err strobe with its cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BAUD = 16;
  localparam int HALF = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // rxd change -> 2 synchroniser edges + IDLE->START edge, then HALF to the
  // start sample, NBITS bit periods to the stop sample; strobe visible after it.
  localparam int DONE_LAT  = 3 + HALF + NBITS * BAUD;
  localparam int FRAME_CYC = (NBITS + 1) * BAUD;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(.BAUD_DIV(BAUD), .HALF_DIV(HALF)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .data_out   (data_out),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks   = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         par_cnt  = 0;
  int         ferr_cyc = 0;
  int         done_cyc  [32];
  logic [7:0] done_data [32];
  logic       done_par  [32];

  always @(negedge clk) begin
    if (rx_done && done_cnt < 32) begin
      done_cyc[done_cnt]  = cyc;
      done_data[done_cnt] = data_out;
      done_par[done_cnt]  = parity_err;
    end
    if (rx_done)    done_cnt = done_cnt + 1;
    if (parity_err) par_cnt  = par_cnt + 1;
    if (frame_err) begin
      ferr_cnt = ferr_cnt + 1;
      ferr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Must be called at a falling edge; leaves rxd at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            output int c0);
    c0  = cyc;
    rxd = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BAUD) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    repeat (BAUD) @(negedge clk);
`else
    if (par) rxd = rxd;
`endif
    rxd = stop;
    repeat (BAUD) @(negedge clk);
  endtask

  function automatic logic epar(input logic [7:0] d);
    return ^d;
  endfunction

  int c0;
  int base;

  initial begin
    reset = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_rx_done",    32'(rx_done),    32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame 0xA5
    base = done_cnt;
    send_frame(8'hA5, epar(8'hA5), 1'b1, c0);
    repeat (4) @(negedge clk);
    check("good_done_cnt", 32'(done_cnt - base), 32'd1);
    check("good_data",     32'(done_data[base]), 32'hA5);
    check("good_latency",  32'(done_cyc[base] - c0), 32'(DONE_LAT));
    check("good_par",      32'(done_par[base]), 32'h0);
    check("good_ferr",     32'(ferr_cnt), 32'd0);
    check("good_busy",     32'(busy), 32'h0);

    // Glitch: 5 cycles low
    base = done_cnt;
    rxd  = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'h1);
    repeat (1) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    check("glitch_no_done", 32'(done_cnt - base), 32'd0);
    check("glitch_data",    32'(data_out), 32'hA5);
    check("glitch_no_ferr", 32'(ferr_cnt), 32'd0);

    // Framing error: 0x3C with low stop, line held low 40 cycles
    base = done_cnt;
    send_frame(8'h3C, epar(8'h3C), 1'b0, c0);
    repeat (24) @(negedge clk);
    check("ferr_cnt",      32'(ferr_cnt), 32'd1);
    check("ferr_latency",  32'(ferr_cyc - c0), 32'(DONE_LAT));
    check("ferr_no_done",  32'(done_cnt - base), 32'd0);
    check("ferr_recover",  32'(busy), 32'h1);
    check("ferr_data",     32'(data_out), 32'hA5);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_idle",     32'(busy), 32'h0);
    repeat (10) @(negedge clk);
    send_frame(8'h5A, epar(8'h5A), 1'b1, c0);
    repeat (4) @(negedge clk);
    check("after_ferr_cnt",  32'(done_cnt - base), 32'd1);
    check("after_ferr_data", 32'(done_data[base]), 32'h5A);
    check("after_ferr_lat",  32'(done_cyc[base] - c0), 32'(DONE_LAT));

    // Back-to-back 0x00, 0xFF, 0x81
    base = done_cnt;
    send_frame(8'h00, epar(8'h00), 1'b1, c0);
    send_frame(8'hFF, epar(8'hFF), 1'b1, c0);
    send_frame(8'h81, epar(8'h81), 1'b1, c0);
    repeat (4) @(negedge clk);
    check("b2b_cnt",    32'(done_cnt - base), 32'd3);
    check("b2b_data0",  32'(done_data[base]),     32'h00);
    check("b2b_data1",  32'(done_data[base + 1]), 32'hFF);
    check("b2b_data2",  32'(done_data[base + 2]), 32'h81);
    check("b2b_gap01",  32'(done_cyc[base + 1] - done_cyc[base]),     32'(FRAME_CYC));
    check("b2b_gap12",  32'(done_cyc[base + 2] - done_cyc[base + 1]), 32'(FRAME_CYC));
    check("b2b_ferr",   32'(ferr_cnt), 32'd1);

    // Reset in the middle of bit 4 of 0x77
    base = done_cnt;
    rxd  = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'(8'h77 >> i);
      repeat (BAUD) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_data",  32'(data_out),   32'h00);
    check("mid_rst_busy",  32'(busy),       32'h0);
    check("mid_rst_done",  32'(rx_done),    32'h0);
    check("mid_rst_ferr",  32'(frame_err),  32'h0);
    check("mid_rst_perr",  32'(parity_err), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (BAUD * 8) @(negedge clk);
    check("mid_no_strobe", 32'(done_cnt - base), 32'd0);
    check("mid_no_ferr",   32'(ferr_cnt), 32'd1);
    send_frame(8'h12, epar(8'h12), 1'b1, c0);
    repeat (4) @(negedge clk);
    check("post_rst_cnt",  32'(done_cnt - base), 32'd1);
    check("post_rst_data", 32'(done_data[base]), 32'h12);
    check("post_rst_out",  32'(data_out), 32'h12);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even parity bit is 1
    base = done_cnt;
    send_frame(8'h07, 1'b1, 1'b1, c0);
    repeat (4) @(negedge clk);
    check("par_ok_cnt",  32'(done_cnt - base), 32'd1);
    check("par_ok_err",  32'(done_par[base]), 32'h0);
    check("par_ok_data", 32'(done_data[base]), 32'h07);
    send_frame(8'h07, 1'b0, 1'b1, c0);
    repeat (4) @(negedge clk);
    check("par_bad_cnt",  32'(done_cnt - base), 32'd2);
    check("par_bad_err",  32'(done_par[base + 1]), 32'h1);
    check("par_bad_data", 32'(done_data[base + 1]), 32'h07);
    check("par_total",    32'(par_cnt), 32'd1);
`else
    check("par_never", 32'(par_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got %0d cycles expected finish", cyc);
    $fatal(1);
  end

endmodule
